// File: rtl/countdown_timer.sv
// BCD countdown timer: loads a preset mm:ss.cc, decrements it to 00:00.00
// and raises a one-cycle alarm.
module countdown_timer #(
    parameter int TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        load,
    input  logic [23:0] set_time,
    input  logic        start,
    input  logic        pause,
    output logic [3:0]  mh,
    output logic [3:0]  ml,
    output logic [3:0]  sh,
    output logic [3:0]  sl,
    output logic [3:0]  msh,
    output logic [3:0]  msl,
    output logic        running,
    output logic        done,
    output logic        alarm,
    output logic        load_err
);

    localparam int            PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

    typedef struct packed {
        logic [3:0] mh;
        logic [3:0] ml;
        logic [3:0] sh;
        logic [3:0] sl;
        logic [3:0] msh;
        logic [3:0] msl;
    } bcd_time_t;

    state_t        state, state_n;
    bcd_time_t     cnt, cnt_n, cnt_dec;
    logic [PW-1:0] presc, presc_n;
    logic          alarm_n, load_err_n;
    logic          tick, cnt_zero;

    function automatic logic time_valid(input bcd_time_t t);
        return (t.mh <= 4'd5) && (t.ml <= 4'd9) && (t.sh <= 4'd5) &&
               (t.sl <= 4'd9) && (t.msh <= 4'd9) && (t.msl <= 4'd9);
    endfunction

    // Borrow ripples from hundredths up to minutes within one edge; the
    // caller guarantees the count is nonzero, so nothing wraps below zero.
    function automatic bcd_time_t dec_time(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (t.msl != 4'd0) r.msl = t.msl - 4'd1;
        else begin
            r.msl = 4'd9;
            if (t.msh != 4'd0) r.msh = t.msh - 4'd1;
            else begin
                r.msh = 4'd9;
                if (t.sl != 4'd0) r.sl = t.sl - 4'd1;
                else begin
                    r.sl = 4'd9;
                    if (t.sh != 4'd0) r.sh = t.sh - 4'd1;
                    else begin
                        r.sh = 4'd5;
                        if (t.ml != 4'd0) r.ml = t.ml - 4'd1;
                        else begin
                            r.ml = 4'd9;
                            r.mh = t.mh - 4'd1;
                        end
                    end
                end
            end
        end
        return r;
    endfunction

    assign tick     = (presc == PRESC_MAX);
    assign cnt_dec  = dec_time(cnt);
    assign cnt_zero = (cnt == '0);

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a value unassigned and no latch is inferred.
        state_n    = state;
        cnt_n      = cnt;
        presc_n    = presc;
        alarm_n    = 1'b0;
        load_err_n = 1'b0;

        if (load && state != S_RUN) begin
            if (time_valid(bcd_time_t'(set_time))) begin
                cnt_n   = bcd_time_t'(set_time);
                state_n = S_IDLE;
                presc_n = '0;
            end else begin
                load_err_n = 1'b1;
            end
        end else begin
            case (state)
                S_RUN: begin
                    if (pause) begin
                        state_n = S_PAUSE;
                    end else if (tick) begin
                        presc_n = '0;
                        cnt_n   = cnt_dec;
                        if (cnt_dec == '0) begin
                            state_n = S_DONE;
                            alarm_n = 1'b1;
                        end
                    end else begin
                        presc_n = presc + PW'(1);
                    end
                end
                S_IDLE: begin
                    if (start && !cnt_zero) begin
                        state_n = S_RUN;
                        presc_n = '0;
                    end
                end
                // Resuming keeps the partial prescaler count from before the pause.
                S_PAUSE: begin
                    if (start && !cnt_zero) state_n = S_RUN;
                end
                default: ;
            endcase
        end
    end

    // NOTE: clr is sampled on the clock edge (synchronous), and all state
    // uses non-blocking assignments so every register updates together.
    always_ff @(posedge clk) begin
        if (clr) begin
            state    <= S_IDLE;
            cnt      <= '0;
            presc    <= '0;
            alarm    <= 1'b0;
            load_err <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            presc    <= presc_n;
            alarm    <= alarm_n;
            load_err <= load_err_n;
        end
    end

    assign {mh, ml, sh, sl, msh, msl} = cnt;
    assign running = (state == S_RUN);
    assign done    = (state == S_DONE);

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: two instances (TICK_DIV 1 and 4)
// checked each cycle against an integer-hundredths reference model.
module tb_countdown_timer;

    logic        clk = 1'b0;
    logic        clr = 1'b0, load = 1'b0, start = 1'b0, pause = 1'b0;
    logic [23:0] set_time = '0;

    logic [3:0] mh1, ml1, sh1, sl1, msh1, msl1;
    logic [3:0] mh4, ml4, sh4, sl4, msh4, msl4;
    logic       running1, done1, alarm1, load_err1;
    logic       running4, done4, alarm4, load_err4;

    countdown_timer #(.TICK_DIV(1)) u_dut1 (
        .clk(clk), .clr(clr), .load(load), .set_time(set_time),
        .start(start), .pause(pause),
        .mh(mh1), .ml(ml1), .sh(sh1), .sl(sl1), .msh(msh1), .msl(msl1),
        .running(running1), .done(done1), .alarm(alarm1), .load_err(load_err1)
    );

    countdown_timer #(.TICK_DIV(4)) u_dut4 (
        .clk(clk), .clr(clr), .load(load), .set_time(set_time),
        .start(start), .pause(pause),
        .mh(mh4), .ml(ml4), .sh(sh4), .sl(sl4), .msh(msh4), .msl(msl4),
        .running(running4), .done(done4), .alarm(alarm4), .load_err(load_err4)
    );

    always #5 clk = ~clk;

    wire [23:0] dig1 = {mh1, ml1, sh1, sl1, msh1, msl1};
    wire [23:0] dig4 = {mh4, ml4, sh4, sl4, msh4, msl4};
    wire [3:0]  fl1  = {running1, done1, alarm1, load_err1};
    wire [3:0]  fl4  = {running4, done4, alarm4, load_err4};

    typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_DONE} mst_t;

    typedef struct {
        mst_t st;
        int   cnt;    // remaining time in hundredths of a second
        int   presc;
        bit   alarm;
        bit   lerr;
    } mdl_t;

    typedef struct {
        logic [23:0] dig1;
        logic [23:0] dig4;
        logic [3:0]  fl1;
        logic [3:0]  fl4;
    } exp_t;

    exp_t sb_q[$];
    mdl_t m1, m4;
    int   n_vec = 0;
    int   n_mis = 0;

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, want %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit bcd_valid(input logic [23:0] v);
        logic [3:0] d [6];
        for (int i = 0; i < 6; i++) d[i] = v[23-4*i -: 4];
        return d[0] <= 5 && d[1] <= 9 && d[2] <= 5 && d[3] <= 9 && d[4] <= 9 && d[5] <= 9;
    endfunction

    function automatic int bcd_to_h(input logic [23:0] v);
        int mins, secs, hund;
        mins = 10 * int'(v[23:20]) + int'(v[19:16]);
        secs = 10 * int'(v[15:12]) + int'(v[11:8]);
        hund = 10 * int'(v[7:4]) + int'(v[3:0]);
        return mins * 6000 + secs * 100 + hund;
    endfunction

    function automatic logic [23:0] h_to_bcd(input int h);
        int mins, secs, hund;
        mins = h / 6000;
        secs = (h / 100) % 60;
        hund = h % 100;
        return {4'(mins / 10), 4'(mins % 10), 4'(secs / 10), 4'(secs % 10),
                4'(hund / 10), 4'(hund % 10)};
    endfunction

    function automatic logic [3:0] flags_of(input mdl_t m);
        return {m.st == M_RUN, m.st == M_DONE, m.alarm, m.lerr};
    endfunction

    function automatic mdl_t step(input mdl_t m, input int td, input bit c, input bit l,
                                  input logic [23:0] st, input bit s, input bit p);
        mdl_t n;
        n = m;
        n.alarm = 0;
        n.lerr  = 0;
        if (c) begin
            n.st = M_IDLE; n.cnt = 0; n.presc = 0;
            return n;
        end
        if (l && m.st != M_RUN) begin
            if (bcd_valid(st)) begin
                n.cnt = bcd_to_h(st); n.st = M_IDLE; n.presc = 0;
            end else begin
                n.lerr = 1;
            end
        end else if (m.st == M_RUN) begin
            if (p) n.st = M_PAUSE;
            else if (m.presc == td - 1) begin
                n.presc = 0;
                n.cnt   = m.cnt - 1;
                if (n.cnt == 0) begin
                    n.st = M_DONE; n.alarm = 1;
                end
            end else n.presc = m.presc + 1;
        end else if (s && m.cnt != 0 && (m.st == M_IDLE || m.st == M_PAUSE)) begin
            if (m.st == M_IDLE) n.presc = 0;
            n.st = M_RUN;
        end
        return n;
    endfunction

    // Drive one cycle of stimulus, push the model's prediction, then pop and
    // compare it against both instances just after the clock edge.
    task automatic cyc(input bit c, input bit l, input logic [23:0] st, input bit s, input bit p);
        exp_t e;
        exp_t got;
        @(negedge clk);
        clr = c; load = l; set_time = st; start = s; pause = p;
        m1 = step(m1, 1, c, l, st, s, p);
        m4 = step(m4, 4, c, l, st, s, p);
        e.dig1 = h_to_bcd(m1.cnt);
        e.dig4 = h_to_bcd(m4.cnt);
        e.fl1  = flags_of(m1);
        e.fl4  = flags_of(m4);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        check("dig1", dig1, got.dig1);
        check("flags1", {20'h0, fl1}, {20'h0, got.fl1});
        check("dig4", dig4, got.dig4);
        check("flags4", {20'h0, fl4}, {20'h0, got.fl4});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 24'h0, 0, 0);
    endtask

    task automatic do_clr();
        cyc(1, 0, 24'h0, 0, 0);
    endtask

    task automatic do_load(input logic [23:0] v);
        cyc(0, 1, v, 0, 0);
    endtask

    task automatic do_start();
        cyc(0, 0, 24'h0, 1, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1);
    end

    initial begin
        logic [23:0] rv;
        int          r;
        m1 = '{M_IDLE, 0, 0, 0, 0};
        m4 = '{M_IDLE, 0, 0, 0, 0};

        // Reset state
        do_clr();
        check("rst_dig", dig1, 24'h000000);
        check("rst_flags", {20'h0, fl1}, 24'h0);

        // Three-hundredth countdown at one tick per clock
        do_clr();
        do_load(24'h000003);
        do_start();
        idle(1); check("t2_msl2", {20'h0, msl1}, 24'd2);
        idle(1); check("t2_msl1", {20'h0, msl1}, 24'd1);
        idle(1); check("t2_msl0", {20'h0, msl1}, 24'd0);
        check("t2_done_alarm", {22'h0, done1, alarm1}, 24'b11);
        idle(1); check("t2_alarm_fall", {22'h0, done1, alarm1}, 24'b10);

        // Borrow chain
        do_clr(); do_load(24'h100000); do_start(); idle(1);
        check("borrow_full", dig1, 24'h095999);
        do_clr(); do_load(24'h000100); do_start(); idle(1);
        check("borrow_sec", dig1, 24'h000099);
        do_clr(); do_load(24'h010000); do_start(); idle(1);
        check("borrow_min", dig1, 24'h005999);

        // Rejected loads, and a load ignored while running
        do_clr(); do_load(24'h000500);
        do_load(24'h006000);
        check("bad_sh_err", {23'h0, load_err1}, 24'd1);
        check("bad_sh_dig", dig1, 24'h000500);
        idle(1); check("err_pulse", {23'h0, load_err1}, 24'd0);
        do_load(24'h00000A);
        check("bad_msl_err", {23'h0, load_err1}, 24'd1);
        do_start(); idle(1);
        do_load(24'h000300);
        check("run_load_ign", {22'h0, running1, load_err1}, 24'b10);

        // clr mid-count
        do_clr();
        check("clr_mid", {dig1, 4'h0} == 28'h0 ? 24'h0 : dig1, 24'h0);
        check("clr_flags", {16'h0, fl1, fl4}, 24'h0);

        // Pause / resume with a TICK_DIV=4 prescaler
        do_clr(); do_load(24'h000002); do_start();
        idle(2);
        cyc(0, 0, 24'h0, 0, 1);
        check("pause_run4", {23'h0, running4}, 24'd0);
        idle(10);
        check("pause_hold4", dig4, 24'h000002);
        do_start();
        idle(1); check("resume_msl2", {20'h0, msl4}, 24'd2);
        idle(1); check("resume_msl1", {20'h0, msl4}, 24'd1);
        idle(3); check("resume_notdone", {23'h0, done4}, 24'd0);
        idle(1); check("resume_done", {22'h0, done4, alarm4}, 24'b11);

        // pause and start together while running: pause wins
        do_clr(); do_load(24'h000010); do_start(); idle(1);
        cyc(0, 0, 24'h0, 1, 1);
        check("pause_wins", {22'h0, running1, running4}, 24'b00);
        check("pause_wins_dig", dig1, 24'h000009);
        do_start();
        check("resume_run", {22'h0, running1, running4}, 24'b11);

        // Zero / DONE guards
        do_clr(); do_load(24'h000000); do_start();
        check("zero_start", {22'h0, running1, alarm1}, 24'b00);
        do_load(24'h000001); do_start(); idle(1);
        do_start();
        check("done_start", {22'h0, done1, running1}, 24'b10);
        do_load(24'h00F000);
        check("done_badload", {22'h0, done1, load_err1}, 24'b11);
        do_load(24'h000500);
        check("done_reload", {22'h0, done1, 1'b0}, 24'b00);
        check("done_reload_dig", dig1, 24'h000500);

        // Random traffic checked against the model only
        for (int i = 0; i < 500; i++) begin
            r = $urandom_range(0, 99);
            if (r < 6) begin
                rv = h_to_bcd($urandom_range(0, 40));
                cyc(0, 1, rv, 0, 0);
            end else if (r < 8) begin
                rv = 24'($urandom) | 24'h00000A;
                cyc(0, 1, rv, 0, 0);
            end else if (r < 20) cyc(0, 0, 24'h0, 1, 0);
            else if (r < 24) cyc(0, 0, 24'h0, 0, 1);
            else if (r < 26) cyc(0, 0, 24'h0, 1, 1);
            else if (r < 27) do_clr();
            else idle(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
